// File: rtl/seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_scheduler
// Description : Round-robin scheduler that shares one pattern-match datapath
//               among NUM_CH serial bit-stream requesters. Each accepted bit
//               is shifted into its channel's private history, which is
//               compared against a runtime-programmable pattern. A match is
//               reported one cycle later on det_valid/det_ch and counted in a
//               saturating match_total.
//               Optional build macro: SEQ_DETECT_SCHED_NONOVERLAP_EN
//               (defined = history/fill of a channel clear after its match,
//               giving non-overlapping detection).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_scheduler #(
    parameter int                 NUM_CH      = 4,
    parameter int                 PAT_LEN     = 7,
    parameter logic [PAT_LEN-1:0] DEFAULT_PAT = 7'b1101100,
    parameter int                 CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH-1:0]         ch_bit,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic                      cfg_we,
    input  logic [PAT_LEN-1:0]        cfg_pattern,
    output logic                      det_valid,
    output logic [$clog2(NUM_CH)-1:0] det_ch,
    output logic [CNT_W-1:0]          match_total
);

    localparam int                CH_W         = $clog2(NUM_CH);
    localparam int                c_FILL_W     = $clog2(PAT_LEN + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_MIN = c_FILL_W'(PAT_LEN - 1);
    localparam logic [CH_W-1:0]   c_RR_RESET   = CH_W'(NUM_CH - 1);

    logic [PAT_LEN-1:0]  r_pattern;
    logic [CH_W-1:0]     r_rr_ptr;
    logic                r_det_valid;
    logic [CH_W-1:0]     r_det_ch;
    logic [CNT_W-1:0]    r_match_total;

    logic [PAT_LEN-1:0]  w_hist [NUM_CH];
    logic [c_FILL_W-1:0] w_fill [NUM_CH];

    logic                w_gnt_any;
    logic [CH_W-1:0]     w_gnt_idx;
    int                  w_best_dist;
    logic                w_xfer;
    logic [PAT_LEN-1:0]  w_new_hist;
    logic                w_match;

    // Round-robin search: the valid channel closest after r_rr_ptr (with wrap) wins.
    always_comb begin
        w_gnt_any   = 1'b0;
        w_gnt_idx   = '0;
        w_best_dist = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i] &&
                (((i - int'(r_rr_ptr) - 1 + NUM_CH) % NUM_CH) < w_best_dist)) begin
                w_best_dist = (i - int'(r_rr_ptr) - 1 + NUM_CH) % NUM_CH;
                w_gnt_idx   = CH_W'(i);
                w_gnt_any   = 1'b1;
            end
        end
    end

    // One-hot accept strobe; configuration writes and reset block all grants.
    always_comb begin
        ch_ready = '0;
        if (!rst && en && !cfg_we && w_gnt_any) begin
            ch_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign w_xfer     = |ch_ready;
    assign w_new_hist = {w_hist[w_gnt_idx][PAT_LEN-2:0], ch_bit[w_gnt_idx]};
    assign w_match    = w_xfer && (w_fill[w_gnt_idx] >= c_FILL_MIN) &&
                        (w_new_hist == r_pattern);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PAT_LEN-1:0]  r_hist;
        logic [c_FILL_W-1:0] r_fill;

        // Per-channel history shift register and saturating fill count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hist <= '0;
                r_fill <= '0;
            end else if (cfg_we) begin
                r_hist <= '0;
                r_fill <= '0;
            end else if (ch_ready[g]) begin
`ifdef SEQ_DETECT_SCHED_NONOVERLAP_EN
                if (w_match) begin
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_hist <= {r_hist[PAT_LEN-2:0], ch_bit[g]};
                    r_fill <= (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;
                end
`else
                r_hist <= {r_hist[PAT_LEN-2:0], ch_bit[g]};
                r_fill <= (r_fill == c_FILL_MAX) ? r_fill : r_fill + 1'b1;
`endif
            end
        end

        assign w_hist[g] = r_hist;
        assign w_fill[g] = r_fill;
    end

    // Shared state: pattern, arbitration pointer, detection pulse and match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern     <= DEFAULT_PAT;
            r_rr_ptr      <= c_RR_RESET;
            r_det_valid   <= 1'b0;
            r_det_ch      <= '0;
            r_match_total <= '0;
        end else begin
            if (cfg_we) begin
                r_pattern <= cfg_pattern;
            end
            if (w_xfer) begin
                r_rr_ptr <= w_gnt_idx;
            end
            r_det_valid <= w_match;
            if (w_match) begin
                r_det_ch <= w_gnt_idx;
                if (r_match_total != {CNT_W{1'b1}}) begin
                    r_match_total <= r_match_total + 1'b1;
                end
            end
        end
    end

    assign det_valid   = r_det_valid;
    assign det_ch      = r_det_ch;
    assign match_total = r_match_total;

endmodule
`default_nettype wire
